acc_sched: RTL and testbench

Round-robin scheduler sharing the single `accumulator` datapath between NREQ neuron requesters in the NAR-Net inference pipeline. For each granted job it clears the accumulator, streams the requester's LEN signed 8-bit terms into it under valid/ready flow control, and returns the final sum tagged with the requester ID over a valid/ready result port. It is the only block that drives the accumulator's control inputs.

---
 rtl/acc_sched_pkg.sv | 23 ++
 rtl/acc_sched_if.sv | 38 +++
 rtl/acc_sched_rr_arbiter.sv | 32 +++
 rtl/acc_sched.sv | 151 +++++++++++++++
 tb/tb_acc_sched.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/acc_sched_pkg.sv
// Shared types and defaults for the acc_sched accumulator scheduler.
package acc_sched_pkg;

  localparam int unsigned NREQ_DEF  = 4;
  localparam int unsigned LEN_W_DEF = 8;
  localparam int unsigned SUM_W_DEF = 16;
  localparam int unsigned RES_W_DEF = 8;

  // Scheduler FSM states
  typedef enum logic [2:0] {
    StIdle,
    StClr,
    StRun,
    StWait,
    StOut
  } state_e;

  // Requester index width; never below one bit so ports stay legal
  function automatic int unsigned id_w(input int unsigned nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

endpackage

// File: rtl/acc_sched_if.sv
// Requester, accumulator and result signals of acc_sched.
// master: scheduler view; slave: requesters/accumulator/result sink view.
interface acc_sched_if
  import acc_sched_pkg::*;
#(
  parameter int unsigned NREQ  = NREQ_DEF,
  parameter int unsigned LEN_W = LEN_W_DEF,
  parameter int unsigned SUM_W = SUM_W_DEF,
  parameter int unsigned RES_W = RES_W_DEF,
  parameter int unsigned ID_W  = id_w(NREQ)
);

  logic [NREQ-1:0]       req;
  logic [NREQ*LEN_W-1:0] req_len;
  logic [NREQ-1:0]       gnt;
  logic [NREQ*8-1:0]     in_data;
  logic [NREQ-1:0]       in_valid;
  logic [NREQ-1:0]       in_ready;
  logic                  acc_clr;
  logic                  acc_en;
  logic [7:0]            acc_a;
  logic [SUM_W-1:0]      acc_sum;
  logic                  res_valid;
  logic                  res_ready;
  logic [ID_W-1:0]       res_id;
  logic [RES_W-1:0]      res_sum;

  modport master (
    input  req, req_len, in_data, in_valid, acc_sum, res_ready,
    output gnt, in_ready, acc_clr, acc_en, acc_a, res_valid, res_id, res_sum
  );

  modport slave (
    output req, req_len, in_data, in_valid, acc_sum, res_ready,
    input  gnt, in_ready, acc_clr, acc_en, acc_a, res_valid, res_id, res_sum
  );

endinterface

// File: rtl/acc_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request after i_last_id, wrapping.
module acc_sched_rr_arbiter
  import acc_sched_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned ID_W = id_w(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [ID_W-1:0] i_last_id,
  output logic            o_valid,
  output logic [NREQ-1:0] o_gnt,
  output logic [ID_W-1:0] o_idx
);

  // Scan last_id+1 .. last_id+NREQ (mod NREQ); the first hit wins
  always_comb begin
    int unsigned cand;
    cand    = 0;
    o_valid = 1'b0;
    o_gnt   = '0;
    o_idx   = '0;
    for (int k = 1; k <= int'(NREQ); k++) begin
      cand = (32'(i_last_id) + 32'(k)) % NREQ;
      if (!o_valid && i_req[cand[ID_W-1:0]]) begin
        o_valid                 = 1'b1;
        o_gnt[cand[ID_W-1:0]]   = 1'b1;
        o_idx                   = cand[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/acc_sched.sv
// acc_sched: round-robin scheduler sharing one accumulator between NREQ requesters.
// Each job: clear accumulator, stream LEN terms, return the sum tagged with the ID.
// Optional macro ACC_SAT_EN: saturate the result to RES_W signed instead of wrapping.
module acc_sched
  import acc_sched_pkg::*;
#(
  parameter int unsigned NREQ  = NREQ_DEF,
  parameter int unsigned LEN_W = LEN_W_DEF,
  parameter int unsigned SUM_W = SUM_W_DEF,
  parameter int unsigned RES_W = RES_W_DEF
) (
  input logic         clk,
  input logic         rst_n,
  acc_sched_if.master bus
);

  localparam int unsigned ID_W = id_w(NREQ);

  state_e           r_state;
  logic [ID_W-1:0]  r_id;
  logic [ID_W-1:0]  r_last_id;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_cnt;
  logic [NREQ-1:0]  r_gnt;
  logic [NREQ-1:0]  r_in_ready;
  logic             r_acc_clr;
  logic             r_res_valid;
  logic [ID_W-1:0]  r_res_id;
  logic [RES_W-1:0] r_res_sum;

  logic             w_arb_valid;
  logic [NREQ-1:0]  w_arb_gnt;
  logic [ID_W-1:0]  w_arb_idx;
  logic [LEN_W-1:0] w_req_len_sel;
  logic             w_hs;
  logic [7:0]       w_term;
  logic [RES_W-1:0] w_res;

  acc_sched_rr_arbiter #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_arb (
    .i_req     (bus.req),
    .i_last_id (r_last_id),
    .o_valid   (w_arb_valid),
    .o_gnt     (w_arb_gnt),
    .o_idx     (w_arb_idx)
  );

  assign w_req_len_sel = bus.req_len[32'(w_arb_idx)*LEN_W +: LEN_W];
  assign w_term        = bus.in_data[32'(r_id)*8 +: 8];

  // in_ready is only ever set for the granted requester, so this is the term handshake.
  // acc_en must be combinational so the accumulator adds on the same edge as the handshake.
  assign w_hs = bus.in_valid[r_id] & r_in_ready[r_id];

`ifdef ACC_SAT_EN
  localparam logic signed [SUM_W-1:0] ResMax =
    SUM_W'((longint'(1) <<< (RES_W - 1)) - longint'(1));
  localparam logic signed [SUM_W-1:0] ResMin = ~ResMax;

  logic signed [SUM_W-1:0] w_sum_s;
  assign w_sum_s = bus.acc_sum;

  // Clamp the signed sum into the signed RES_W range
  always_comb begin
    w_res = w_sum_s[RES_W-1:0];
    if (w_sum_s > ResMax) begin
      w_res = ResMax[RES_W-1:0];
    end else if (w_sum_s < ResMin) begin
      w_res = ResMin[RES_W-1:0];
    end
  end
`else
  assign w_res = bus.acc_sum[RES_W-1:0];
`endif

  // Job sequencing FSM; all control outputs except acc_en/acc_a are registered here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_id        <= '0;
      r_last_id   <= ID_W'(NREQ - 1);
      r_len       <= '0;
      r_cnt       <= '0;
      r_gnt       <= '0;
      r_in_ready  <= '0;
      r_acc_clr   <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_id    <= '0;
      r_res_sum   <= '0;
    end else begin
      r_acc_clr <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_arb_valid) begin
            r_id      <= w_arb_idx;
            r_len     <= w_req_len_sel;
            r_cnt     <= '0;
            r_gnt     <= w_arb_gnt;
            r_acc_clr <= 1'b1;
            r_state   <= StClr;
          end
        end
        StClr: begin
          if (r_len != '0) begin
            r_in_ready <= r_gnt;
            r_state    <= StRun;
          end else begin
            r_state <= StWait;
          end
        end
        StRun: begin
          if (w_hs) begin
            r_cnt <= r_cnt + LEN_W'(1);
            if (r_cnt == r_len - LEN_W'(1)) begin
              r_in_ready <= '0;
              r_state    <= StWait;
            end
          end
        end
        StWait: begin
          // acc_sum now includes the last term
          r_res_sum   <= w_res;
          r_res_id    <= r_id;
          r_res_valid <= 1'b1;
          r_state     <= StOut;
        end
        StOut: begin
          if (bus.res_ready) begin
            r_res_valid <= 1'b0;
            r_last_id   <= r_id;
            r_gnt       <= '0;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.in_ready  = r_in_ready;
  assign bus.acc_clr   = r_acc_clr;
  assign bus.acc_en    = w_hs;
  assign bus.acc_a     = w_hs ? w_term : 8'h00;
  assign bus.res_valid = r_res_valid;
  assign bus.res_id    = r_res_id;
  assign bus.res_sum   = r_res_sum;

endmodule

// File: tb/tb_acc_sched.sv
// Self-checking bench for acc_sched: accumulator model, per-requester term feeders,
// result scoreboard, a vector table of single jobs and hand-written corner sequences.
module tb_acc_sched;
  import acc_sched_pkg::*;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned LEN_W = 8;
  localparam int unsigned SUM_W = 16;
  localparam int unsigned RES_W = 8;
  localparam int unsigned ID_W  = id_w(NREQ);
  localparam int          NVEC  = 9;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  acc_sched_if #(
    .NREQ  (NREQ),
    .LEN_W (LEN_W),
    .SUM_W (SUM_W),
    .RES_W (RES_W)
  ) bus ();

  acc_sched #(
    .NREQ  (NREQ),
    .LEN_W (LEN_W),
    .SUM_W (SUM_W),
    .RES_W (RES_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Accumulator model: registered sum, clear has priority
  logic [SUM_W-1:0] acc_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else if (bus.acc_clr) acc_q <= '0;
    else if (bus.acc_en) acc_q <= acc_q + SUM_W'($signed(bus.acc_a));
  end
  assign bus.acc_sum = acc_q;

  typedef struct {
    int id;
    int sum;
  } exp_t;

  typedef struct {
    int              id;
    int              len;
    logic [3:0][7:0] d;
    int              exp_wrap;
    int              exp_sat;
  } vec_t;

  vec_t            vecs [NVEC];
  exp_t            sb [$];
  int              q_data [NREQ][$];
  logic [NREQ-1:0] hold_valid;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int t0, clr_cyc, val_cyc, acc_cyc, en_cnt;
  bit rdy_seen;
  bit prev_hold;
  logic [ID_W-1:0]  held_id;
  logic [RES_W-1:0] held_sum;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_vec(input int i, input int id, input int len, input int a, input int b,
                         input int c, input int d, input int ew, input int es);
    vecs[i].id       = id;
    vecs[i].len      = len;
    vecs[i].d[0]     = 8'(a);
    vecs[i].d[1]     = 8'(b);
    vecs[i].d[2]     = 8'(c);
    vecs[i].d[3]     = 8'(d);
    vecs[i].exp_wrap = ew;
    vecs[i].exp_sat  = es;
  endtask

  task automatic push_exp(input int id, input int sum);
    exp_t e;
    e.id  = id;
    e.sum = sum;
    sb.push_back(e);
  endtask

  // Requesters with pending terms present them; idle ones drive random noise
  task automatic drive_inputs();
    for (int i = 0; i < int'(NREQ); i++) begin
      if (q_data[i].size() > 0) begin
        bus.in_valid[i]      = !hold_valid[i];
        bus.in_data[i*8 +: 8] = 8'(q_data[i][0]);
      end else begin
        bus.in_valid[i]      = 1'($urandom_range(0, 1));
        bus.in_data[i*8 +: 8] = 8'($urandom);
      end
    end
  endtask

  task automatic start_job(input int id, input int len);
    bus.req_len[id*LEN_W +: LEN_W] = LEN_W'(len);
    bus.req[id] = 1'b1;
    drive_inputs();
  endtask

  task automatic clear_job_stats();
    t0       = cyc;
    clr_cyc  = -1;
    val_cyc  = -1;
    acc_cyc  = -1;
    en_cnt   = 0;
    rdy_seen = 1'b0;
  endtask

  // One clock: check at the falling edge, update stimulus 1 time unit after the rising edge
  task automatic tick();
    logic [NREQ-1:0] hs;
    logic            take;
    logic [ID_W-1:0] take_id;
    int              g;
    exp_t            e;
    @(negedge clk);
    hs = bus.in_valid & bus.in_ready;
    chk("clr_en_excl", longint'(bus.acc_clr && bus.acc_en), 0);
    chk("ready_outside_gnt", longint'(bus.in_ready & ~bus.gnt), 0);
    chk("acc_en", longint'(bus.acc_en), longint'(|hs));
    if (bus.acc_clr) clr_cyc = cyc;
    if (bus.in_ready != '0) rdy_seen = 1'b1;
    if (bus.acc_en) begin
      en_cnt++;
      g = -1;
      for (int i = 0; i < int'(NREQ); i++) if (bus.gnt[i]) g = i;
      if (g < 0) chk("acc_en_without_gnt", 1, 0);
      else if (q_data[g].size() == 0) chk("extra_term", 1, 0);
      else chk("acc_a", longint'($signed(bus.acc_a)), longint'(q_data[g][0]));
    end
    if (prev_hold) begin
      chk("res_valid_hold", longint'(bus.res_valid), 1);
      chk("res_id_hold", longint'(bus.res_id), longint'(held_id));
      chk("res_sum_hold", longint'(bus.res_sum), longint'(held_sum));
    end
    if (bus.res_valid && val_cyc < 0) val_cyc = cyc;
    prev_hold = bus.res_valid && !bus.res_ready;
    held_id   = bus.res_id;
    held_sum  = bus.res_sum;
    take      = bus.res_valid && bus.res_ready;
    take_id   = bus.res_id;
    if (take) begin
      acc_cyc = cyc;
      if (sb.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("res_id", longint'(take_id), longint'(e.id));
        chk("res_sum", longint'($signed(bus.res_sum)), longint'(e.sum));
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (hs[i] && q_data[i].size() > 0) void'(q_data[i].pop_front());
    end
    if (take) bus.req[take_id] = 1'b0;
    drive_inputs();
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (sb.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    chk("results_within_budget", longint'(sb.size()), 0);
    sb.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_gnt"}, longint'(bus.gnt), 0);
    chk({tag, "_in_ready"}, longint'(bus.in_ready), 0);
    chk({tag, "_acc_clr"}, longint'(bus.acc_clr), 0);
    chk({tag, "_acc_en"}, longint'(bus.acc_en), 0);
    chk({tag, "_acc_a"}, longint'(bus.acc_a), 0);
    chk({tag, "_res_valid"}, longint'(bus.res_valid), 0);
    chk({tag, "_res_id"}, longint'(bus.res_id), 0);
    chk({tag, "_res_sum"}, longint'(bus.res_sum), 0);
  endtask

  task automatic flush_env();
    sb.delete();
    for (int i = 0; i < int'(NREQ); i++) q_data[i].delete();
    bus.req    = '0;
    hold_valid = '0;
    prev_hold  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    flush_env();
    rst_n = 1'b1;
    drive_inputs();
  endtask

  task automatic run_vec(input vec_t v);
    int exp_sum;
`ifdef ACC_SAT_EN
    exp_sum = v.exp_sat;
`else
    exp_sum = v.exp_wrap;
`endif
    for (int k = 0; k < v.len; k++) q_data[v.id].push_back(int'($signed(v.d[k])));
    push_exp(v.id, exp_sum);
    clear_job_stats();
    start_job(v.id, v.len);
    tick();
    // Length changes after the latch must be ignored
    bus.req_len[v.id*LEN_W +: LEN_W] = LEN_W'($urandom);
    wait_done(60);
    chk("clr_cycle", longint'(clr_cyc - t0), 1);
    chk("valid_cycle", longint'(val_cyc - t0), longint'(v.len + 3));
    chk("acc_en_count", longint'(en_cnt), longint'(v.len));
    chk("in_ready_seen", longint'(rdy_seen), longint'(v.len != 0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n         = 1'b1;
    bus.req       = '0;
    bus.req_len   = '0;
    bus.in_valid  = '0;
    bus.in_data   = '0;
    bus.res_ready = 1'b1;
    hold_valid    = '0;
    prev_hold     = 1'b0;
    held_id       = '0;
    held_sum      = '0;
    clear_job_stats();

    //      i  id len  terms                    wrap  sat
    set_vec(0, 0, 3,    5,   -2,   10,    0,    13,   13);
    set_vec(1, 2, 0,    0,    0,    0,    0,     0,    0);
    set_vec(2, 1, 4,  127,  127,  127,  127,    -4,  127);
    set_vec(3, 3, 2, -100, -100,    0,    0,    56, -128);
    set_vec(4, 1, 1,   -1,    0,    0,    0,    -1,   -1);
    set_vec(5, 3, 4,  100,  -50,  -60,   20,    10,   10);
    set_vec(6, 0, 4, -128, -128, -128, -128,     0, -128);
    set_vec(7, 2, 3,   64,   64,   -1,    0,   127,  127);
    set_vec(8, 2, 3,   64,   64,    0,    0,  -128,  127);

    do_reset();

    // Two simultaneous requesters right after reset: 0 then 1, and again 0 then 1
    q_data[0].push_back(7);
    q_data[1].push_back(-3);
    push_exp(0, 7);
    push_exp(1, -3);
    clear_job_stats();
    start_job(0, 1);
    start_job(1, 1);
    wait_done(40);
    q_data[0].push_back(20);
    q_data[1].push_back(21);
    push_exp(0, 20);
    push_exp(1, 21);
    start_job(0, 1);
    start_job(1, 1);
    wait_done(40);

    for (int i = 0; i < NVEC; i++) run_vec(vecs[i]);

    // Input gap of 3 cycles between terms, then result held off for 5 cycles
    bus.res_ready = 1'b0;
    q_data[1].push_back(50);
    q_data[1].push_back(60);
    push_exp(1, 110);
    clear_job_stats();
    start_job(1, 2);
    n = 0;
    while (en_cnt == 0 && n < 20) begin
      tick();
      n++;
    end
    hold_valid[1] = 1'b1;
    drive_inputs();
    repeat (3) begin
      tick();
      chk("gnt_held_stall", longint'(bus.gnt), 2);
    end
    hold_valid[1] = 1'b0;
    drive_inputs();
    n = 0;
    while (val_cyc < 0 && n < 20) begin
      tick();
      n++;
    end
    repeat (4) begin
      tick();
      chk("gnt_held_out", longint'(bus.gnt), 2);
    end
    bus.res_ready = 1'b1;
    wait_done(10);
    chk("stall_acc_en_count", longint'(en_cnt), 2);
    chk("stall_valid_cycle", longint'(val_cyc - t0), 8);
    chk("stall_accept_cycle", longint'(acc_cyc - t0), 13);

    // Reset in the middle of a len-5 job, then a fresh len-2 job
    for (int k = 1; k <= 5; k++) q_data[0].push_back(k);
    push_exp(0, 15);
    clear_job_stats();
    start_job(0, 5);
    n = 0;
    while (en_cnt < 2 && n < 20) begin
      tick();
      n++;
    end
    chk("mid_job_terms", longint'(en_cnt), 2);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    @(posedge clk);
    #1;
    check_reset_outputs("rst_hold");
    flush_env();
    rst_n = 1'b1;
    drive_inputs();
    set_vec(0, 0, 2, 3, 4, 0, 0, 7, 7);
    run_vec(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
